// File: rtl/exc_dec_pkg.sv
// Shared definitions for the LEGv8 main decoder: opcodes, exception status codes,
// controller states and the packed datapath control bus.
package exc_dec_pkg;

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_MRS  = 11'h6A9;
  localparam logic [10:0] OP_ERET = 11'h6B4;
  localparam logic [7:0]  OP_CBZ_HI = 8'hB4;

  localparam logic [3:0] ES_NONE     = 4'b0000;
  localparam logic [3:0] ES_IRQ      = 4'b0001;
  localparam logic [3:0] ES_INVOP    = 4'b0010;
  localparam logic [3:0] ES_ERET_RUN = 4'b0011;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    HANDLER = 2'd2
  } exc_state_e;

  typedef struct packed {
    logic [1:0] alusrc;
    logic       reg2loc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/ctrl_table_dec.sv
// Pure combinational LEGv8 opcode table: opcode -> control bus, legality and ERET flag.
module ctrl_table_dec
  import exc_dec_pkg::*;
(
  input  logic [10:0] op,
  output ctrl_t       ctrl,
  output logic        valid_op,
  output logic        is_eret
);

  always_comb begin
    ctrl     = '0;
    valid_op = 1'b1;
    is_eret  = 1'b0;
    // CBZ owns a whole 8-bit prefix, so it is matched before the full-width table
    if (op[10:3] == OP_CBZ_HI) begin
      ctrl.reg2loc = 1'b1;
      ctrl.branch  = 1'b1;
      ctrl.aluop   = 2'b01;
    end else begin
      case (op)
        OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
          ctrl.regwrite = 1'b1;
          ctrl.aluop    = 2'b10;
        end
        OP_LDUR: begin
          ctrl.alusrc   = 2'b01;
          ctrl.memtoreg = 1'b1;
          ctrl.regwrite = 1'b1;
          ctrl.memread  = 1'b1;
        end
        OP_STUR: begin
          ctrl.reg2loc  = 1'b1;
          ctrl.alusrc   = 2'b01;
          ctrl.memwrite = 1'b1;
        end
        OP_MRS: begin
          ctrl.reg2loc  = 1'b1;
          ctrl.alusrc   = 2'b10;
          ctrl.regwrite = 1'b1;
          ctrl.aluop    = 2'b01;
        end
        OP_ERET: begin
          ctrl.branch = 1'b1;
          ctrl.aluop  = 2'b01;
          is_eret     = 1'b1;
        end
        default: valid_op = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/exc_main_decoder.sv
// Registered LEGv8 main decoder with exception controller (RUN -> FLUSH -> HANDLER -> RUN).
// External interrupt support is compiled in when EXC_IRQ_EN is defined.
module exc_main_decoder
  import exc_dec_pkg::*;
#(
  parameter int OP_W      = 11,
  parameter int PC_W      = 64,
  parameter int NUM_IRQ   = 4,
  parameter int ESTATUS_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  input  logic                 stall,
  input  logic [OP_W-1:0]      Op,
  input  logic [PC_W-1:0]      pc_i,
  input  logic [NUM_IRQ-1:0]   irq,
  output logic [1:0]           ALUSrc,
  output logic                 Reg2Loc,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 Branch,
  output logic [1:0]           ALUOp,
  output logic                 ERet,
  output logic                 exc_taken,
  output logic                 flush,
  output logic                 in_handler,
  output logic [ESTATUS_W-1:0] EStatus,
  output logic [PC_W-1:0]      ELR,
  output logic [NUM_IRQ-1:0]   irq_ack
);

  ctrl_t                dec_ctrl;
  logic                 dec_valid;
  logic                 dec_eret;
  logic                 vld_p0;
  logic                 irq_req;
  logic [NUM_IRQ-1:0]   irq_sel;

  exc_state_e           state_p1, state_nxt;
  ctrl_t                ctrl_p1, ctrl_nxt;
  logic                 eret_p1, eret_nxt;
  logic                 exc_p1, exc_nxt;
  logic [NUM_IRQ-1:0]   ack_p1, ack_nxt;
  logic [ESTATUS_W-1:0] es_p1, es_nxt;
  logic [PC_W-1:0]      elr_p1, elr_nxt;

  ctrl_table_dec u_table (
    .op       (Op[OP_W-1 -: 11]),
    .ctrl     (dec_ctrl),
    .valid_op (dec_valid),
    .is_eret  (dec_eret)
  );

  // Stage p0: an instruction is accepted only when not stalled and not flushing
  assign vld_p0 = instr_valid & ~stall & (state_p1 != FLUSH);

`ifdef EXC_IRQ_EN
  // Isolate the lowest set bit: lower index wins
  assign irq_req = |irq;
  assign irq_sel = irq & (~irq + NUM_IRQ'(1));
`else
  logic unused_irq;
  assign unused_irq = ^irq;
  assign irq_req    = 1'b0;
  assign irq_sel    = '0;
`endif

  always_comb begin
    state_nxt = state_p1;
    ctrl_nxt  = '0;
    eret_nxt  = 1'b0;
    exc_nxt   = 1'b0;
    ack_nxt   = '0;
    es_nxt    = es_p1;
    elr_nxt   = elr_p1;
    if (stall) begin
      ctrl_nxt = ctrl_p1;
      eret_nxt = eret_p1;
      exc_nxt  = exc_p1;
      ack_nxt  = ack_p1;
    end else begin
      case (state_p1)
        RUN: begin
          if (vld_p0 && !dec_valid) begin
            es_nxt    = ESTATUS_W'(ES_INVOP);
            elr_nxt   = pc_i;
            exc_nxt   = 1'b1;
            state_nxt = FLUSH;
          end else if (vld_p0 && dec_eret) begin
            es_nxt    = ESTATUS_W'(ES_ERET_RUN);
            elr_nxt   = pc_i;
            exc_nxt   = 1'b1;
            state_nxt = FLUSH;
          end else if (irq_req) begin
            es_nxt    = ESTATUS_W'(ES_IRQ);
            elr_nxt   = pc_i;
            exc_nxt   = 1'b1;
            ack_nxt   = irq_sel;
            state_nxt = FLUSH;
          end else if (vld_p0) begin
            ctrl_nxt = dec_ctrl;
          end
        end
        FLUSH: state_nxt = HANDLER;
        HANDLER: begin
          // No nesting: a bad opcode here only records status and becomes a bubble
          if (vld_p0 && !dec_valid) begin
            es_nxt = ESTATUS_W'(ES_INVOP);
          end else if (vld_p0) begin
            ctrl_nxt = dec_ctrl;
            if (dec_eret) begin
              eret_nxt  = 1'b1;
              state_nxt = RUN;
            end
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Stage p1: registered control bus and exception state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p1 <= RUN;
      ctrl_p1  <= '0;
      eret_p1  <= 1'b0;
      exc_p1   <= 1'b0;
      ack_p1   <= '0;
      es_p1    <= '0;
      elr_p1   <= '0;
    end else begin
      state_p1 <= state_nxt;
      ctrl_p1  <= ctrl_nxt;
      eret_p1  <= eret_nxt;
      exc_p1   <= exc_nxt;
      ack_p1   <= ack_nxt;
      es_p1    <= es_nxt;
      elr_p1   <= elr_nxt;
    end
  end

  assign ALUSrc     = ctrl_p1.alusrc;
  assign Reg2Loc    = ctrl_p1.reg2loc;
  assign MemtoReg   = ctrl_p1.memtoreg;
  assign RegWrite   = ctrl_p1.regwrite;
  assign MemRead    = ctrl_p1.memread;
  assign MemWrite   = ctrl_p1.memwrite;
  assign Branch     = ctrl_p1.branch;
  assign ALUOp      = ctrl_p1.aluop;
  assign ERet       = eret_p1;
  assign exc_taken  = exc_p1;
  assign flush      = (state_p1 == FLUSH);
  assign in_handler = (state_p1 == HANDLER);
  assign EStatus    = es_p1;
  assign ELR        = elr_p1;
  assign irq_ack    = ack_p1;

endmodule

// File: tb/tb_exc_main_decoder.sv
// Directed self-checking bench for exc_main_decoder; IRQ vectors switch with EXC_IRQ_EN.
module tb_exc_main_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic        stall = 1'b0;
  logic [10:0] Op = '0;
  logic [63:0] pc_i = '0;
  logic [3:0]  irq = '0;
  logic [1:0]  ALUSrc, ALUOp;
  logic        Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic        ERet, exc_taken, flush, in_handler;
  logic [3:0]  EStatus, irq_ack;
  logic [63:0] ELR;
  logic [9:0]  bus;

  int n_checks = 0;
  int n_fail   = 0;

  // Bus layout: ALUSrc, Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp
  localparam logic [9:0] B_ZERO = 10'b00_000000_00;
  localparam logic [9:0] B_R    = 10'b00_001000_10;
  localparam logic [9:0] B_LDUR = 10'b01_011100_00;
  localparam logic [9:0] B_STUR = 10'b01_100010_00;
  localparam logic [9:0] B_CBZ  = 10'b00_100001_01;
  localparam logic [9:0] B_MRS  = 10'b10_101000_01;
  localparam logic [9:0] B_ERET = 10'b00_000001_01;

  assign bus = {ALUSrc, Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp};

  exc_main_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .instr_valid(instr_valid),
    .stall      (stall),
    .Op         (Op),
    .pc_i       (pc_i),
    .irq        (irq),
    .ALUSrc     (ALUSrc),
    .Reg2Loc    (Reg2Loc),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Branch     (Branch),
    .ALUOp      (ALUOp),
    .ERet       (ERet),
    .exc_taken  (exc_taken),
    .flush      (flush),
    .in_handler (in_handler),
    .EStatus    (EStatus),
    .ELR        (ELR),
    .irq_ack    (irq_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [10:0] op, input logic [63:0] pc);
    instr_valid = v;
    Op          = op;
    pc_i        = pc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus", bus, B_ZERO);
    check("rst_es", EStatus, 4'h0);
    check("rst_elr", ELR, 64'h0);
    check("rst_hdl", in_handler, 1'b0);
    check("rst_flush", flush, 1'b0);
    reset = 1'b1;

    cyc(1, 11'h7C2, 64'h40);
    check("ldur_bus", bus, B_LDUR);
    check("ldur_exc", exc_taken, 1'b0);
    cyc(1, 11'h658, 64'h44);
    check("sub_bus", bus, B_R);
    cyc(1, 11'h7C0, 64'h48);
    check("stur_bus", bus, B_STUR);
    cyc(1, 11'h5A3, 64'h4C);
    check("cbz_bus", bus, B_CBZ);
    cyc(1, 11'h6A9, 64'h50);
    check("mrs_bus", bus, B_MRS);
    cyc(0, 11'h7C2, 64'h54);
    check("bubble_bus", bus, B_ZERO);

    cyc(1, 11'h7C2, 64'h58);
    stall = 1'b1;
    cyc(1, 11'h458, 64'h5C);
    check("stall_hold", bus, B_LDUR);
    stall = 1'b0;

    // Invalid opcode in RUN, then the full handler round trip
    cyc(1, 11'h000, 64'h100);
    check("inv_exc", exc_taken, 1'b1);
    check("inv_flush", flush, 1'b1);
    check("inv_es", EStatus, 4'h2);
    check("inv_elr", ELR, 64'h100);
    check("inv_bus", bus, B_ZERO);
    cyc(1, 11'h7C2, 64'h200);
    check("fl_bus", bus, B_ZERO);
    check("fl_hdl", in_handler, 1'b1);
    check("fl_flush", flush, 1'b0);
    check("fl_exc", exc_taken, 1'b0);
    cyc(1, 11'h7C2, 64'h204);
    check("h_ldur", bus, B_LDUR);
    cyc(1, 11'h000, 64'h300);
    check("h_inv_es", EStatus, 4'h2);
    check("h_inv_elr", ELR, 64'h100);
    check("h_inv_exc", exc_taken, 1'b0);
    check("h_inv_bus", bus, B_ZERO);
    check("h_inv_hdl", in_handler, 1'b1);
    cyc(1, 11'h6B4, 64'h304);
    check("eret", ERet, 1'b1);
    check("eret_bus", bus, B_ERET);
    check("eret_hdl", in_handler, 1'b0);
    check("eret_es", EStatus, 4'h2);
    cyc(1, 11'h458, 64'h308);
    check("post_eret", ERet, 1'b0);
    check("post_bus", bus, B_R);

    // ERET in RUN, then stall through FLUSH
    cyc(1, 11'h6B4, 64'h500);
    check("er_es", EStatus, 4'h3);
    check("er_exc", exc_taken, 1'b1);
    check("er_eret", ERet, 1'b0);
    check("er_elr", ELR, 64'h500);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 11'h7C2, 64'h504);
      check("stl_flush", flush, 1'b1);
      check("stl_hdl", in_handler, 1'b0);
    end
    stall = 1'b0;
    cyc(0, 11'h0, 64'h508);
    check("stl_rel_hdl", in_handler, 1'b1);
    check("stl_rel_fl", flush, 1'b0);
    irq = 4'b1010;
    cyc(1, 11'h458, 64'h50C);
    check("h_irq_ack", irq_ack, 4'b0000);
    check("h_irq_exc", exc_taken, 1'b0);
    check("h_irq_bus", bus, B_R);
    irq = 4'b0000;

    // Asynchronous reset while in HANDLER
    instr_valid = 1'b1;
    Op = 11'h7C2;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    check("hrst_bus", bus, B_ZERO);
    check("hrst_hdl", in_handler, 1'b0);
    check("hrst_elr", ELR, 64'h0);
    check("hrst_es", EStatus, 4'h0);
    reset = 1'b1;
    cyc(1, 11'h7C2, 64'h600);
    check("hrst_run", bus, B_LDUR);

`ifdef EXC_IRQ_EN
    irq = 4'b1010;
    cyc(1, 11'h458, 64'h600);
    check("irq_ack", irq_ack, 4'b0010);
    check("irq_es", EStatus, 4'h1);
    check("irq_rw", RegWrite, 1'b0);
    check("irq_elr", ELR, 64'h600);
    irq = 4'b0000;
    cyc(0, 11'h0, 64'h0);
    check("irq_ack_pulse", irq_ack, 4'b0000);
    cyc(1, 11'h6B4, 64'h604);
    irq = 4'b0100;
    cyc(0, 11'h0, 64'h700);
    check("irqnv_ack", irq_ack, 4'b0100);
    check("irqnv_elr", ELR, 64'h700);
    irq = 4'b0000;
    cyc(0, 11'h0, 64'h0);
    cyc(1, 11'h6B4, 64'h704);
    irq = 4'b0001;
    cyc(1, 11'h000, 64'h800);
    check("pri_es", EStatus, 4'h2);
    check("pri_ack", irq_ack, 4'b0000);
    cyc(0, 11'h0, 64'h0);
    cyc(1, 11'h6B4, 64'h804);
    cyc(0, 11'h0, 64'h900);
    check("retry_es", EStatus, 4'h1);
    check("retry_ack", irq_ack, 4'b0001);
    check("retry_elr", ELR, 64'h900);
    irq = 4'b0000;
`else
    irq = 4'b1010;
    cyc(1, 11'h458, 64'h600);
    check("noirq_ack", irq_ack, 4'b0000);
    check("noirq_exc", exc_taken, 1'b0);
    check("noirq_bus", bus, B_R);
    irq = 4'b0000;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
